// File: rtl/instr_encoder.sv
// Encodes decoded operations into 16-bit instruction words, buffers them in a
// small FIFO and writes them to instruction memory from a programmable base.
module instr_encoder #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs,
   input  logic [3:0]        in_rt,
   input  logic [7:0]        in_imm,
   input  logic              in_last,
   input  logic              imem_busy,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              done,
   output logic              overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic              overflow_reg;
   logic              imem_we_reg;
   logic [ADDR_W-1:0] imem_addr_reg;
   logic [15:0]       imem_wdata_reg;
   logic              done_reg;

   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [3:0]        opcode;
   logic [15:0]       enc_word;
   logic              fifo_full, fifo_empty;
   logic              push, pop;

   // Opcode map and field packing, mirroring the core's decoder
   always_comb begin
      opcode = 4'b0000;
      case (in_class)
         3'd0: opcode = 4'b0000;
         3'd1: opcode = 4'b1000;
         3'd2: opcode = 4'b1001;
         3'd3: opcode = 4'b0101;
         3'd4: opcode = 4'b0010;
         3'd5: opcode = 4'b1010;
         3'd6: opcode = 4'b0110;
         3'd7: opcode = 4'b1011;
         default: opcode = 4'b0000;
      endcase
   end

   always_comb begin
      enc_word = {opcode, in_rd, in_rs, in_imm[3:0]};
      case (in_class)
         3'd0, 3'd4, 3'd6: enc_word = {opcode, in_rd, in_rs, in_rt};
         3'd7:             enc_word = {opcode, in_rd, in_imm};
         default:          enc_word = {opcode, in_rd, in_rs, in_imm[3:0]};
      endcase
   end

   assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign push       = in_valid && in_ready;
   assign pop        = !fifo_empty && !imem_busy;

   // Ready comes from registered state and count only, so a full FIFO stays
   // not-ready even in a cycle where the head is being popped.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            in_ready = !fifo_full;
            if (in_valid && !fifo_full && in_last) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_empty) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Write stage; once the address space is exhausted, popped words are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_reg    <= '0;
         overflow_reg   <= 1'b0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         done_reg       <= 1'b0;
      end else begin
         imem_we_reg <= 1'b0;
         done_reg    <= (state_reg == ST_DRAIN) && fifo_empty && !pop;
         if (state_reg == ST_IDLE && start) begin
            wr_addr_reg  <= base_addr;
            overflow_reg <= 1'b0;
         end else if (pop && !overflow_reg) begin
            imem_we_reg    <= 1'b1;
            imem_addr_reg  <= wr_addr_reg;
            imem_wdata_reg <= fifo_mem[rd_ptr_reg];
            wr_addr_reg    <= wr_addr_reg + ADDR_W'(1);
            if (wr_addr_reg == '1) overflow_reg <= 1'b1;
         end
      end
   end

   assign imem_we    = imem_we_reg;
   assign imem_addr  = imem_addr_reg;
   assign imem_wdata = imem_wdata_reg;
   assign done       = done_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected memory writes,
// a negedge monitor checks every imem_we and every done pulse.
module tb_instr_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] base_addr = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_class = '0;
   logic [3:0] in_rd = '0, in_rs = '0, in_rt = '0;
   logic [7:0] in_imm = '0;
   logic       in_last = 1'b0;
   logic       imem_busy = 1'b0;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [15:0] imem_wdata;
   logic       done;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  m_addr = '0;
   logic        m_ovf = 1'b0;
   logic        strict = 1'b0;

   instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
      .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
      .in_last(in_last), .imem_busy(imem_busy), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .done(done),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   function automatic logic [15:0] enc(input int cls, input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [3:0] rt, input logic [7:0] imm);
      logic [3:0] op;
      case (cls)
         0: op = 4'h0;  1: op = 4'h8;  2: op = 4'h9;  3: op = 4'h5;
         4: op = 4'h2;  5: op = 4'hA;  6: op = 4'h6;  default: op = 4'hB;
      endcase
      if (cls == 0 || cls == 4 || cls == 6) return {op, rd, rs, rt};
      if (cls == 7) return {op, rd, imm};
      return {op, rd, rs, imm[3:0]};
   endfunction

   // Monitor: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h", imem_addr, imem_wdata);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               if ({imem_addr, imem_wdata} !== e) begin
                  errors++;
                  $display("FAIL write addr=%0h data=%0h expected addr=%0h data=%0h",
                           imem_addr, imem_wdata, e[23:16], e[15:0]);
               end else begin
                  $display("ok   write addr=%0h data=%0h", imem_addr, imem_wdata);
               end
            end
         end
         if (done) begin
            done_cnt++;
            checks++;
            if (imem_we || exp_q.size() != 0) begin
               errors++;
               $display("FAIL done_early we=%0b pending=%0d expected we=0 pending=0",
                        imem_we, exp_q.size());
            end else begin
               $display("ok   done pulse");
            end
         end
      end
   end

   task automatic do_start(input logic [7:0] base);
      start = 1'b1;
      base_addr = base;
      @(posedge clk); #1;
      start = 1'b0;
      m_addr = base;
      m_ovf = 1'b0;
   endtask

   task automatic send(input logic [2:0] cls, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [7:0] imm, input logic last,
                       input logic [15:0] word);
      int tries;
      logic acc;
      in_valid = 1'b1; in_class = cls; in_rd = rd; in_rs = rs; in_rt = rt;
      in_imm = imm; in_last = last;
      if (!m_ovf) begin
         exp_q.push_back({m_addr, word});
         if (m_addr == 8'hFF) m_ovf = 1'b1;
         m_addr = m_addr + 8'd1;
      end
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         tries++;
      end
      if (!acc) chk("accept_timeout", 32'(tries), 32'd0);
      if (strict) chk("pp_ready_first_try", 32'(tries), 32'd1);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      int d0;
      d0 = done_cnt;
      t = 0;
      while (done_cnt == d0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk(name, 32'(done_cnt - d0), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] cls_words [8];
      int w0;
      cls_words = '{16'h0123, 16'h8125, 16'h9125, 16'h5125,
                    16'h2123, 16'hA125, 16'h6123, 16'hB1A5};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(imem_we), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_done_ovf", 32'({done, overflow}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: single word, write appears in the cycle after edge k+1
      do_start(8'h40);
      send(3'd0, 4'h4, 4'h5, 4'h6, 8'h00, 1'b1, enc(0, 4'h4, 4'h5, 4'h6, 8'h00));
      @(negedge clk);
      chk("lat_we_k", 32'(imem_we), 0);
      @(negedge clk);
      chk("lat_we_k1", 32'(imem_we), 1);
      wait_done("lat_done");

      // All eight classes
      do_start(8'h10);
      for (int i = 0; i < 8; i++)
         send(3'(i), 4'h1, 4'h2, 4'h3, 8'hA5, (i == 7), cls_words[i]);
      wait_done("classes_done");
      chk("classes_left", 32'(exp_q.size()), 0);

      // Back-pressure: FIFO fills to 4, ready drops, nothing written while busy
      imem_busy = 1'b1;
      w0 = wr_cnt;
      do_start(8'h80);
      for (int i = 0; i < 4; i++)
         send(3'd4, 4'(i), 4'h7, 4'h8, 8'h00, 1'b0, enc(4, 4'(i), 4'h7, 4'h8, 8'h00));
      in_valid = 1'b1; in_class = 3'd1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(in_ready), 0);
         chk("bp_no_write", 32'(wr_cnt - w0), 0);
      end
      @(posedge clk); #1;
      imem_busy = 1'b0;
      send(3'd1, 4'h9, 4'h3, 4'h0, 8'h3C, 1'b0, enc(1, 4'h9, 4'h3, 4'h0, 8'h3C));
      send(3'd7, 4'hF, 4'h0, 4'h0, 8'h5A, 1'b1, enc(7, 4'hF, 4'h0, 4'h0, 8'h5A));
      wait_done("bp_done");
      chk("bp_writes", 32'(wr_cnt - w0), 6);

      // Reset mid-session with 3 words buffered
      imem_busy = 1'b1;
      do_start(8'h50);
      for (int i = 0; i < 3; i++)
         send(3'd2, 4'h2, 4'h2, 4'h0, 8'h01, 1'b0, enc(2, 4'h2, 4'h2, 4'h0, 8'h01));
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_outs", 32'({imem_we, imem_addr, imem_wdata, done, overflow}), 0);
      chk("mid_rst_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      imem_busy = 1'b0;
      rst_n = 1'b1;
      w0 = wr_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("mid_rst_no_write", 32'(wr_cnt - w0), 0);

      // Wrap: only 0xFE and 0xFF are written, overflow sets, done still pulses
      w0 = wr_cnt;
      do_start(8'hFE);
      for (int i = 0; i < 4; i++)
         send(3'd5, 4'(i), 4'h1, 4'h0, 8'h0E, (i == 3), enc(5, 4'(i), 4'h1, 4'h0, 8'h0E));
      wait_done("wrap_done");
      chk("wrap_writes", 32'(wr_cnt - w0), 2);
      chk("wrap_overflow", 32'(overflow), 1);

      // New start clears overflow and restarts at the new base
      do_start(8'h30);
      chk("restart_ovf_clear", 32'(overflow), 0);
      send(3'd6, 4'h3, 4'h4, 4'h5, 8'h00, 1'b1, enc(6, 4'h3, 4'h4, 4'h5, 8'h00));
      wait_done("restart_done");

      // Continuous stream with busy=0: ready holds, one write per cycle
      w0 = wr_cnt;
      strict = 1'b1;
      do_start(8'h60);
      for (int i = 0; i < 8; i++)
         send(3'(i), 4'(i), 4'(i + 1), 4'(i + 2), 8'(8'h11 * i), (i == 7),
              enc(i, 4'(i), 4'(i + 1), 4'(i + 2), 8'(8'h11 * i)));
      strict = 1'b0;
      wait_done("pp_done");
      chk("pp_writes", 32'(wr_cnt - w0), 8);

      // Start during RUN ignored; in_valid in IDLE ignored
      do_start(8'h20);
      send(3'd0, 4'h1, 4'h1, 4'h1, 8'h00, 1'b0, enc(0, 4'h1, 4'h1, 4'h1, 8'h00));
      send(3'd0, 4'h2, 4'h2, 4'h2, 8'h00, 1'b0, enc(0, 4'h2, 4'h2, 4'h2, 8'h00));
      start = 1'b1; base_addr = 8'hC0;
      @(posedge clk); #1;
      start = 1'b0;
      send(3'd3, 4'h3, 4'h3, 4'h0, 8'h07, 1'b0, enc(3, 4'h3, 4'h3, 4'h0, 8'h07));
      send(3'd1, 4'h4, 4'h4, 4'h0, 8'h08, 1'b1, enc(1, 4'h4, 4'h4, 4'h0, 8'h08));
      wait_done("proto_done");
      w0 = wr_cnt;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready_low", 32'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_no_write", 32'(wr_cnt - w0), 0);
      chk("final_queue_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Program-load-side counterpart of the opcode decoder.
- Accepts decoded operations (class plus register/immediate fields) over a valid/ready handshake and encodes each into a 16-bit instruction word.
- Buffers words in a small FIFO and writes them to instruction memory at consecutive addresses from a programmable base.
- Sits between the test/boot loader and the instruction memory of the single-cycle core.

## Interface

Parameters:
- ADDR_W, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, >=2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a load session (honoured only in IDLE)
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  operation present
- in_ready  out  1  block accepts operation this cycle
- in_class  in  3  0 R-arith, 1 I-arith, 2 load, 3 store, 4 R-comp, 5 I-comp, 6 branch, 7 JAL
- in_rd, in_rs, in_rt  in  4 each  register fields
- in_imm  in  8  immediate
- in_last  in  1  marks final operation of the session
- imem_busy  in  1  memory cannot accept a write this cycle
- imem_we  out  1  registered write strobe, one cycle per word
- imem_addr  out  ADDR_W  registered write address
- imem_wdata  out  16  registered instruction word
- done  out  1  one-cycle pulse when the session is complete
- overflow  out  1  sticky; an address past all-ones was needed

## Operation

- Opcode map: class 0..7 maps to 0000, 1000, 1001, 0101, 0010, 1010, 0110, 1011.
- Word for classes 0, 4, 6: {opcode, rd, rs, rt}.
- Word for classes 1, 2, 3, 5: {opcode, rd, rs, imm[3:0]}; imm[7:4] is ignored.
- Word for class 7: {opcode, rd, imm[7:0]}.
- Encoding is combinational at the FIFO input; the FIFO stores finished 16-bit words.
- State machine:
  - IDLE: in_ready=0. On start, load wr_addr=base_addr, clear overflow, go to RUN.
  - RUN: in_ready = !fifo_full. An accept with in_last=1 goes to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty, assert done for one cycle and go to IDLE.
- Write stage runs whenever the FIFO is non-empty and imem_busy=0:
  - pop the head;
  - if overflow=0, register imem_we=1 with imem_addr=wr_addr and imem_wdata=head, then wr_addr++;
  - else drop the word with imem_we=0.
- Wrap-around: a write issued at wr_addr = all-ones sets overflow. wr_addr wraps to 0 but no further writes issue until the next start.
- Simultaneous push and pop: count is unchanged and FIFO order is preserved.
- A full FIFO with a same-cycle pop still holds in_ready=0, since ready is derived from the registered count.
- start outside IDLE is ignored. in_valid in IDLE or DRAIN is ignored.

## Timing

- Reset values: state IDLE, FIFO empty, wr_addr=0, imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, done=0, overflow=0.
- Reset mid-session: buffered words are discarded and no further imem_we is issued.
- Latency: for a word accepted at edge k with the FIFO otherwise empty and imem_busy=0 at edge k+1, imem_we is high for the cycle after edge k+1.
- Throughput is one word per cycle while imem_busy=0.
- imem_busy is sampled at the edge. If busy=1 the head is held and imem_we=0 in the next cycle; the word issues at the first edge with busy=0.
- imem_we never stays high for two cycles on the same word.
- done is registered: high for the cycle after the edge where state is DRAIN, the FIFO is empty and no pop occurs.
- done is never asserted in the same cycle as imem_we for the last word; done comes at least one cycle later.

## Test plan

- Reset values: assert rst_n=0 mid-session with 3 words buffered → all outputs 0 immediately, no imem_we after release.
- All classes: base 0x10, send the 8 classes with rd=1, rs=2, rt=3, imm=0xA5 (last on JAL) → addresses 0x10..0x17 receive 0x0123, 0x8125, 0x9125, 0x5125, 0x2123, 0xA125, 0x6123, 0xB1A5; then done pulses once.
- Back-pressure: hold imem_busy=1 while streaming 6 words → in_ready drops after 4 accepts (FIFO full), no imem_we. Release busy → 6 consecutive writes, in order, no duplicates.
- Wrap: ADDR_W=8, base 0xFE, 4 words → writes to 0xFE and 0xFF only, overflow=1, done still pulses, no write to 0x00.
- Simultaneous push/pop: continuous in_valid with busy=0 → one imem_we per cycle, FIFO count stable, in_ready never drops.
- Protocol: start during RUN ignored (addresses continue incrementing); in_valid in IDLE ignored; a new start after done clears overflow and restarts at the new base.
